// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor
// Samples a 4-bit Johnson counter bus and decodes it into a phase index and a
// one-hot phase strobe. A four-state tracker checks that the code sequence
// advances legally. It counts completed revolutions and sequence errors.
//
// Qualifier semantics: sample_en is a pure qualifier with no back-pressure.
// q_in is consumed on every rising edge where sample_en = 1. It is ignored on
// all other edges. clear_err is honoured on any edge, whatever sample_en is.
module johnson_phase_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q_in,
  input  logic       sample_en,
  input  logic       clear_err,
  output logic [2:0] phase,
  output logic [7:0] phase_onehot,
  output logic       phase_valid,
  output logic       locked,
  output logic       fault,
  output logic       err_pulse,
  output logic [7:0] cycle_count,
  output logic [7:0] err_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);

  state_t     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic       prev_valid_q, prev_valid_d;
  logic [3:0] run_q, run_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] onehot_q, onehot_d;
  logic       valid_q, valid_d;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] cycle_q, cycle_d;
  logic [7:0] errc_q, errc_d;
  logic       locked_q, locked_d;
  logic       fault_q, fault_d;

  logic       code_legal;
  logic [2:0] code_idx;
  logic [2:0] prev_inc;
  logic [3:0] run_inc;
  logic       is_adv;
  logic       is_hold;
  logic       seq_err;
  logic       err_any;
  logic       count_err;

  // Decode the Johnson code into a phase index; 8 of 16 codes are illegal.
  always_comb begin
    code_legal = 1'b1;
    code_idx   = 3'd0;
    case (q_in)
      4'b0000: code_idx = 3'd0;
      4'b1000: code_idx = 3'd1;
      4'b1100: code_idx = 3'd2;
      4'b1110: code_idx = 3'd3;
      4'b1111: code_idx = 3'd4;
      4'b0111: code_idx = 3'd5;
      4'b0011: code_idx = 3'd6;
      4'b0001: code_idx = 3'd7;
      default: code_legal = 1'b0;
    endcase
  end

  // Classify the current sample against the stored previous phase.
  always_comb begin
    prev_inc  = prev_q + 3'd1;
    run_inc   = run_q + 4'd1;
    is_adv    = sample_en && code_legal && prev_valid_q && (code_idx == prev_inc);
    is_hold   = sample_en && code_legal && prev_valid_q && (code_idx == prev_q);
    seq_err   = sample_en && code_legal && prev_valid_q && !is_adv && !(is_hold && ALLOW_HOLD);
    err_any   = sample_en && (!code_legal || seq_err);
    count_err = err_any && (state_q != ST_ACQUIRE);
  end

  // Next-state, datapath and output computation.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    run_d        = run_q;
    phase_d      = phase_q;
    onehot_d     = 8'd0;
    valid_d      = valid_q;
    err_pulse_d  = count_err;
    cycle_d      = cycle_q;
    errc_d       = errc_q;

    if (sample_en) begin
      if (code_legal) begin
        phase_d      = code_idx;
        valid_d      = 1'b1;
        onehot_d     = 8'd1 << code_idx;
        prev_d       = code_idx;
        prev_valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    case (state_q)
      ST_ACQUIRE: begin
        if (sample_en && code_legal) begin
          state_d = ST_TRACK;
          run_d   = 4'd0;
        end
      end
      ST_TRACK: begin
        if (err_any) begin
          state_d      = ST_ACQUIRE;
          prev_valid_d = 1'b0;
        end else if (is_adv) begin
          run_d = run_inc;
          if (run_inc >= LOCK_TGT) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (err_any) begin
          state_d = ST_FAULT;
        end else if (is_adv && (prev_q == 3'd7) && (cycle_q != 8'hFF)) begin
          cycle_d = cycle_q + 8'd1;
        end
      end
      ST_FAULT: begin
        // A same-edge error keeps the tracker parked in FAULT.
        if (clear_err && !err_any) begin
          state_d      = ST_ACQUIRE;
          prev_valid_d = 1'b0;
        end
      end
      default: state_d = ST_ACQUIRE;
    endcase

    // A new acquisition starts the revolution count afresh.
    if ((state_d == ST_ACQUIRE) && (state_q != ST_ACQUIRE)) cycle_d = 8'd0;

    // A clear beats a simultaneous increment.
    if (clear_err) begin
      errc_d = 8'd0;
    end else if (count_err && (errc_q != 8'hFF)) begin
      errc_d = errc_q + 8'd1;
    end

    locked_d = (state_d == ST_LOCKED);
    fault_d  = (state_d == ST_FAULT);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ACQUIRE;
      prev_q       <= 3'd0;
      prev_valid_q <= 1'b0;
      run_q        <= 4'd0;
      phase_q      <= 3'd0;
      onehot_q     <= 8'd0;
      valid_q      <= 1'b0;
      err_pulse_q  <= 1'b0;
      cycle_q      <= 8'd0;
      errc_q       <= 8'd0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      run_q        <= run_d;
      phase_q      <= phase_d;
      onehot_q     <= onehot_d;
      valid_q      <= valid_d;
      err_pulse_q  <= err_pulse_d;
      cycle_q      <= cycle_d;
      errc_q       <= errc_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  assign phase        = phase_q;
  assign phase_onehot = onehot_q;
  assign phase_valid  = valid_q;
  assign err_pulse    = err_pulse_q;
  assign cycle_count  = cycle_q;
  assign err_count    = errc_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor. Instance u_dut allows holds and
// instance u_nohold rejects them. Both instances share all inputs.
module tb_johnson_phase_monitor;

  localparam logic [1:0] S_ACQ = 2'd0;
  localparam logic [1:0] S_TRK = 2'd1;
  localparam logic [1:0] S_LCK = 2'd2;
  localparam logic [1:0] S_FLT = 2'd3;

  // clock / reset / stimulus signals
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] q_in = 4'd0;
  logic       sample_en = 1'b0;
  logic       clear_err = 1'b0;

  logic [2:0] phase, phase_nh;
  logic [7:0] onehot, onehot_nh;
  logic       valid, valid_nh;
  logic       locked, locked_nh;
  logic       fault, fault_nh;
  logic       errp, errp_nh;
  logic [7:0] cyc, cyc_nh;
  logic [7:0] errc, errc_nh;
  logic [1:0] st, st_nh;

  logic [3:0] codes [8];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  johnson_phase_monitor #(.LOCK_COUNT(4), .ALLOW_HOLD(1'b1)) u_dut (
    .clk(clk), .reset(reset), .q_in(q_in), .sample_en(sample_en), .clear_err(clear_err),
    .phase(phase), .phase_onehot(onehot), .phase_valid(valid), .locked(locked),
    .fault(fault), .err_pulse(errp), .cycle_count(cyc), .err_count(errc), .dbg_state(st)
  );

  johnson_phase_monitor #(.LOCK_COUNT(4), .ALLOW_HOLD(1'b0)) u_nohold (
    .clk(clk), .reset(reset), .q_in(q_in), .sample_en(sample_en), .clear_err(clear_err),
    .phase(phase_nh), .phase_onehot(onehot_nh), .phase_valid(valid_nh), .locked(locked_nh),
    .fault(fault_nh), .err_pulse(errp_nh), .cycle_count(cyc_nh), .err_count(errc_nh),
    .dbg_state(st_nh)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Compares one observed value against the expected value and counts it.
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Driver: applies inputs at the falling edge and returns 1 ns after the next rising edge.
  task automatic step(input logic [3:0] q, input logic en, input logic clr);
    @(negedge clk);
    q_in = q;
    sample_en = en;
    clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input int ph);
    step(codes[ph], 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    q_in = 4'd0;
    sample_en = 1'b0;
    clear_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic lock_from_zero();
    for (int i = 0; i < 5; i++) samp(i);
  endtask

  initial begin
    codes[0] = 4'b0000; codes[1] = 4'b1000; codes[2] = 4'b1100; codes[3] = 4'b1110;
    codes[4] = 4'b1111; codes[5] = 4'b0111; codes[6] = 4'b0011; codes[7] = 4'b0001;

    // Reset state.
    @(negedge clk);
    #1;
    check_eq("rst_phase", 32'(phase), 0);
    check_eq("rst_onehot", 32'(onehot), 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_fault", 32'(fault), 0);
    check_eq("rst_errp", 32'(errp), 0);
    check_eq("rst_cyc", 32'(cyc), 0);
    check_eq("rst_errc", 32'(errc), 0);
    check_eq("rst_state", 32'(st), 32'(S_ACQ));
    reset = 1'b0;

    // Lock acquisition: the phase index and strobe step, and locked rises at the 5th sample.
    for (int i = 0; i < 5; i++) exp_q.push_back(8'd1 << i);
    for (int i = 0; i < 5; i++) begin
      samp(i);
      check_eq("acq_phase", 32'(phase), i);
      check_eq("acq_onehot", 32'(onehot), 32'(exp_q.pop_front()));
      check_eq("acq_valid", 32'(valid), 1);
      check_eq("acq_locked", 32'(locked), (i == 4) ? 1 : 0);
    end
    check_eq("acq_errc", 32'(errc), 0);
    check_eq("acq_state", 32'(st), 32'(S_LCK));

    // Revolution count: phases 5..7, then three full 0..7 passes, give three wraps.
    samp(5); samp(6); samp(7);
    check_eq("rev_cyc0", 32'(cyc), 0);
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 8; p++) begin
        samp(p);
        if (p == 0) check_eq("rev_cyc_wrap", 32'(cyc), r + 1);
      end
    end
    check_eq("rev_cyc3", 32'(cyc), 3);
    check_eq("rev_phase", 32'(phase), 7);

    // Illegal code while locked.
    step(4'b1010, 1'b1, 1'b0);
    check_eq("ill_valid", 32'(valid), 0);
    check_eq("ill_onehot", 32'(onehot), 0);
    check_eq("ill_phase_hold", 32'(phase), 7);
    check_eq("ill_errp", 32'(errp), 1);
    check_eq("ill_errc", 32'(errc), 1);
    check_eq("ill_fault", 32'(fault), 1);
    check_eq("ill_locked", 32'(locked), 0);
    step(4'b0000, 1'b0, 1'b0);
    check_eq("ill_errp_drop", 32'(errp), 0);
    check_eq("ill_fault_stay", 32'(fault), 1);
    step(4'b0000, 1'b0, 1'b1);
    check_eq("clr_fault", 32'(fault), 0);
    check_eq("clr_errc", 32'(errc), 0);
    check_eq("clr_cyc", 32'(cyc), 0);
    check_eq("clr_state", 32'(st), 32'(S_ACQ));
    for (int i = 3; i < 8; i++) begin
      samp(i);
      check_eq("relock_locked", 32'(locked), (i == 7) ? 1 : 0);
    end

    // Sequence skip in TRACK.
    do_reset();
    samp(0); samp(1); samp(3);
    check_eq("skip_errp", 32'(errp), 1);
    check_eq("skip_errc", 32'(errc), 1);
    check_eq("skip_locked", 32'(locked), 0);
    check_eq("skip_state", 32'(st), 32'(S_ACQ));
    check_eq("skip_phase", 32'(phase), 3);

    // Holds and sample_en.
    do_reset();
    samp(0); samp(1); samp(2); samp(2);
    check_eq("hold_errp", 32'(errp), 0);
    check_eq("hold_errc", 32'(errc), 0);
    check_eq("hold_state", 32'(st), 32'(S_TRK));
    check_eq("hold_onehot", 32'(onehot), 32'h04);
    check_eq("nohold_errp", 32'(errp_nh), 1);
    check_eq("nohold_errc", 32'(errc_nh), 1);
    check_eq("nohold_state", 32'(st_nh), 32'(S_ACQ));
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, 1'b0, 1'b0);
      check_eq("nosamp_phase", 32'(phase), 2);
      check_eq("nosamp_valid", 32'(valid), 1);
      check_eq("nosamp_onehot", 32'(onehot), 0);
      check_eq("nosamp_errp", 32'(errp), 0);
    end
    samp(3);
    check_eq("hold_run_locked3", 32'(locked), 0);
    samp(4);
    check_eq("hold_run_locked4", 32'(locked), 1);

    // Asynchronous reset between edges while locked with cycle_count = 2.
    samp(5); samp(6); samp(7);
    for (int p = 0; p < 8; p++) samp(p);
    samp(0);
    check_eq("pre_ar_cyc", 32'(cyc), 2);
    check_eq("pre_ar_locked", 32'(locked), 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("ar_phase", 32'(phase), 0);
    check_eq("ar_onehot", 32'(onehot), 0);
    check_eq("ar_valid", 32'(valid), 0);
    check_eq("ar_locked", 32'(locked), 0);
    check_eq("ar_cyc", 32'(cyc), 0);
    check_eq("ar_state", 32'(st), 32'(S_ACQ));
    @(negedge clk);
    reset = 1'b0;

    // Error and clear_err on the same edge, then error-count saturation in FAULT.
    lock_from_zero();
    step(4'b1010, 1'b1, 1'b1);
    check_eq("errclr_errc", 32'(errc), 0);
    check_eq("errclr_fault", 32'(fault), 1);
    check_eq("errclr_errp", 32'(errp), 1);
    for (int i = 0; i < 300; i++) step(4'b0101, 1'b1, 1'b0);
    check_eq("errc_sat", 32'(errc), 255);
    check_eq("errc_sat_fault", 32'(fault), 1);

    // cycle_count saturation.
    do_reset();
    lock_from_zero();
    samp(5); samp(6); samp(7);
    for (int r = 0; r < 260; r++) begin
      for (int p = 0; p < 8; p++) samp(p);
    end
    check_eq("cyc_sat", 32'(cyc), 255);
    check_eq("cyc_sat_locked", 32'(locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
